// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults and level-width helper for the FWFT FIFO.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam int DEF_ALEN         = 4;
    localparam int DEF_DLEN         = 8;
    localparam int DEF_AEMPTY_LVL   = 2;
    localparam int DEF_AFULL_MARGIN = 2;

    // One extra bit so a completely full FIFO (DEPTH entries) is representable.
    function automatic int lvl_w(input int alen);
        return alen + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram
// Brief    : Simple dual-port storage, one write port, registered read port.
// Revision : 1.0
// ============================================================================
module fifo_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Read-before-write on an address collision; the caller bypasses that case.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : fifo_fwft
// Brief    : First-word-fall-through synchronous FIFO with registered flags.
//            Optional high-water mark enabled by macro FIFO_PEAK_LEVEL_EN.
// Revision : 1.0
// ============================================================================
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int ALEN       = DEF_ALEN,
    parameter int DLEN       = DEF_DLEN,
    parameter int AFULL_LVL  = (2**ALEN) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_flush,
    input  logic                    i_wen,
    input  logic [DLEN-1:0]         i_wdata,
    output logic                    o_wfull,
    output logic                    o_walmost_full,
    output logic                    o_woverflow,
    input  logic                    i_ren,
    output logic [DLEN-1:0]         o_rdata,
    output logic                    o_rempty,
    output logic                    o_ralmost_empty,
    output logic                    o_runderflow,
    output logic [lvl_w(ALEN)-1:0]  o_level,
    output logic [lvl_w(ALEN)-1:0]  o_peak
);

    localparam int             DEPTH      = 2**ALEN;
    localparam int             LW         = lvl_w(ALEN);
    localparam logic [LW-1:0]  AFULL_THR  = LW'(AFULL_LVL);
    localparam logic [LW-1:0]  AEMPTY_THR = LW'(AEMPTY_LVL);

    generate
        if (!(AEMPTY_LVL > 0 && AEMPTY_LVL < AFULL_LVL && AFULL_LVL <= DEPTH)) begin : g_bad_params
            $error("fifo_fwft: thresholds must satisfy 0 < AEMPTY_LVL < AFULL_LVL <= DEPTH");
        end
    endgenerate

    logic [LW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic            empty_q, empty_d, full_q, full_d;
    logic            aempty_q, aempty_d, afull_q, afull_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic            byp_sel_q, byp_sel_d;
    logic [DLEN-1:0] byp_q;
    logic            wr_ok, rd_ok, ram_we;
    logic [DLEN-1:0] ram_rdata;

    always_comb begin
        wr_ok  = i_wen & ~full_q;
        rd_ok  = i_ren & ~empty_q;
        ram_we = wr_ok & ~i_flush;
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + {{ALEN{1'b0}}, wr_ok};
            rptr_d = rptr_q + {{ALEN{1'b0}}, rd_ok};
        end
        level_d  = wptr_d - rptr_d;
        empty_d  = (wptr_d == rptr_d);
        full_d   = (wptr_d[ALEN] != rptr_d[ALEN]) && (wptr_d[ALEN-1:0] == rptr_d[ALEN-1:0]);
        afull_d  = (level_d >= AFULL_THR);
        aempty_d = (level_d <= AEMPTY_THR);
        ovf_d    = ~i_flush & i_wen & full_q;
        udf_d    = ~i_flush & i_ren & empty_q;
        // The word landing on the next head slot is not yet visible through the RAM read.
        byp_sel_d = ram_we && (wptr_q[ALEN-1:0] == rptr_d[ALEN-1:0]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            aempty_q  <= 1'b1;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            byp_sel_q <= 1'b0;
            byp_q     <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            aempty_q  <= aempty_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            byp_sel_q <= byp_sel_d;
            byp_q     <= i_wdata;
        end
    end

    fifo_ram #(
        .AW (ALEN),
        .DW (DLEN)
    ) u_ram (
        .clk     (clk),
        .i_we    (ram_we),
        .i_waddr (wptr_q[ALEN-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (rptr_d[ALEN-1:0]),
        .o_rdata (ram_rdata)
    );

`ifdef FIFO_PEAK_LEVEL_EN
    logic [LW-1:0] peak_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak_q <= '0;
        end else if (i_flush) begin
            peak_q <= '0;
        end else if (level_q > peak_q) begin
            peak_q <= level_q;
        end
    end

    assign o_peak = peak_q;
`else
    assign o_peak = '0;
`endif

    assign o_rdata         = empty_q ? '0 : (byp_sel_q ? byp_q : ram_rdata);
    assign o_rempty        = empty_q;
    assign o_wfull         = full_q;
    assign o_ralmost_empty = aempty_q;
    assign o_walmost_full  = afull_q;
    assign o_woverflow     = ovf_q;
    assign o_runderflow    = udf_q;
    assign o_level         = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_fwft
// Brief    : Scoreboard bench for fifo_fwft (DEPTH=4, AFULL=3, AEMPTY=1).
// Revision : 1.0
// ============================================================================
module tb_fifo_fwft;

    localparam int ALEN  = 2;
    localparam int DLEN  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            i_flush = 1'b0;
    logic            i_wen = 1'b0;
    logic            i_ren = 1'b0;
    logic [DLEN-1:0] i_wdata = '0;
    logic            o_wfull, o_walmost_full, o_woverflow;
    logic            o_rempty, o_ralmost_empty, o_runderflow;
    logic [DLEN-1:0] o_rdata;
    logic [ALEN:0]   o_level, o_peak;

    fifo_fwft #(
        .ALEN       (ALEN),
        .DLEN       (DLEN),
        .AFULL_LVL  (3),
        .AEMPTY_LVL (1)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_flush         (i_flush),
        .i_wen           (i_wen),
        .i_wdata         (i_wdata),
        .o_wfull         (o_wfull),
        .o_walmost_full  (o_walmost_full),
        .o_woverflow     (o_woverflow),
        .i_ren           (i_ren),
        .o_rdata         (o_rdata),
        .o_rempty        (o_rempty),
        .o_ralmost_empty (o_ralmost_empty),
        .o_runderflow    (o_runderflow),
        .o_level         (o_level),
        .o_peak          (o_peak)
    );

    always #5 clk = ~clk;

    int              n_chk  = 0;
    int              n_pass = 0;
    logic [DLEN-1:0] sb [$];
    int              exp_peak = 0;
    logic            exp_ovf = 1'b0;
    logic            exp_udf = 1'b0;
    // {rempty, raempty, wfull, wafull, ovf, udf, level, peak, rdata}
    localparam logic [19:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00};

    task automatic drive(input logic w, input logic [DLEN-1:0] d, input logic r);
        int sz;
        sz      = sb.size();
        i_wen   = w;
        i_wdata = d;
        i_ren   = r;
        exp_ovf = w && (sz == DEPTH);
        exp_udf = r && (sz == 0);
`ifdef FIFO_PEAK_LEVEL_EN
        if (sz > exp_peak) exp_peak = sz;
`endif
        if (r && sz > 0) void'(sb.pop_front());
        if (w && sz < DEPTH) sb.push_back(d);
        @(posedge clk); #1;
        i_wen = 1'b0;
        i_ren = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {o_rempty, o_ralmost_empty, o_wfull, o_walmost_full, o_woverflow,
               o_runderflow, o_level, o_peak, o_rdata};
        n_chk++;
        if (obs !== RESET_VEC) $display("FAIL reset_outputs: got %h, want %h", obs, RESET_VEC);
        else n_pass++;
        #3 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fwft();
        drive(1'b1, 8'hA1, 1'b0);
        n_chk++;
        if ({o_rempty, o_rdata, o_level, o_ralmost_empty} !== {1'b0, 8'hA1, 3'd1, 1'b1})
            $display("FAIL fwft_first_word: empty=%b rdata=%h level=%0d aempty=%b, want 0 a1 1 1",
                     o_rempty, o_rdata, o_level, o_ralmost_empty);
        else n_pass++;
    endtask

    task automatic test_overflow();
        drive(1'b1, 8'hB2, 1'b0);
        drive(1'b1, 8'hB3, 1'b0);
        drive(1'b1, 8'hB4, 1'b0);
        n_chk++;
        if ({o_wfull, o_walmost_full, o_level} !== {1'b1, 1'b1, 3'd4})
            $display("FAIL full_flags: wfull=%b afull=%b level=%0d, want 1 1 4", o_wfull, o_walmost_full, o_level);
        else n_pass++;
        drive(1'b1, 8'hEE, 1'b0);
        n_chk++;
        if ({o_woverflow, o_level} !== {exp_ovf, 3'(sb.size())})
            $display("FAIL overflow_pulse: ovf=%b level=%0d, want %b %0d", o_woverflow, o_level, exp_ovf, sb.size());
        else n_pass++;
        drive(1'b0, 8'h00, 1'b0);
        n_chk++;
        if (o_woverflow !== 1'b0) $display("FAIL overflow_one_cycle: ovf=%b, want 0", o_woverflow);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (o_rdata !== sb[0]) $display("FAIL overflow_pop_order[%0d]: rdata=%h, want %h", i, o_rdata, sb[0]);
            else n_pass++;
            drive(1'b0, 8'h00, 1'b1);
        end
        n_chk++;
        if ({o_rempty, o_level} !== {1'b1, 3'd0})
            $display("FAIL drained: empty=%b level=%0d, want 1 0", o_rempty, o_level);
        else n_pass++;
    endtask

    task automatic test_underflow_write();
        drive(1'b1, 8'h5C, 1'b1);
        n_chk++;
        if ({o_runderflow, o_level, o_rdata, o_rempty} !== {exp_udf, 3'd1, 8'h5C, 1'b0})
            $display("FAIL underflow_with_write: udf=%b level=%0d rdata=%h empty=%b, want 1 1 5c 0",
                     o_runderflow, o_level, o_rdata, o_rempty);
        else n_pass++;
        drive(1'b0, 8'h00, 1'b0);
        n_chk++;
        if (o_runderflow !== 1'b0) $display("FAIL underflow_one_cycle: udf=%b, want 0", o_runderflow);
        else n_pass++;
    endtask

    task automatic test_full_pop_write();
        drive(1'b1, 8'hC1, 1'b0);
        drive(1'b1, 8'hC2, 1'b0);
        drive(1'b1, 8'hC3, 1'b0);
        drive(1'b1, 8'h77, 1'b1);
        n_chk++;
        if ({o_woverflow, o_level, o_wfull, o_rdata} !== {exp_ovf, 3'd3, 1'b0, sb[0]})
            $display("FAIL full_pop_write: ovf=%b level=%0d full=%b rdata=%h, want 1 3 0 %h",
                     o_woverflow, o_level, o_wfull, o_rdata, sb[0]);
        else n_pass++;
        while (sb.size() > 0) begin
            n_chk++;
            if (o_rdata !== sb[0]) $display("FAIL full_pop_order: rdata=%h, want %h", o_rdata, sb[0]);
            else n_pass++;
            drive(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_wrap();
        logic w, r;
        for (int i = 0; i < 10; i++) begin
            w = (i % 3) != 2;
            r = (i % 2) == 1;
            if (r && sb.size() > 0) begin
                n_chk++;
                if (o_rdata !== sb[0]) $display("FAIL wrap_data[%0d]: rdata=%h, want %h", i, o_rdata, sb[0]);
                else n_pass++;
            end
            drive(w, 8'h30 + 8'(i), r);
            n_chk++;
            if ({o_level, o_woverflow, o_runderflow} !== {3'(sb.size()), exp_ovf, exp_udf})
                $display("FAIL wrap_level[%0d]: level=%0d ovf=%b udf=%b, want %0d %b %b",
                         i, o_level, o_woverflow, o_runderflow, sb.size(), exp_ovf, exp_udf);
            else n_pass++;
        end
        drive(1'b0, 8'h00, 1'b0);
        n_chk++;
        if (o_peak !== 3'(exp_peak)) $display("FAIL wrap_peak: peak=%0d, want %0d", o_peak, exp_peak);
        else n_pass++;
    endtask

    task automatic test_flush();
        while (sb.size() > 3) drive(1'b0, 8'h00, 1'b1);
        while (sb.size() < 3) drive(1'b1, 8'h90 + 8'(sb.size()), 1'b0);
        i_flush = 1'b1;
        i_wen   = 1'b1;
        i_wdata = 8'hFF;
        sb.delete();
        exp_peak = 0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_wen   = 1'b0;
        n_chk++;
        if ({o_level, o_rempty, o_woverflow, o_peak, o_rdata} !== {3'd0, 1'b1, 1'b0, 3'd0, 8'h00})
            $display("FAIL flush: level=%0d empty=%b ovf=%b peak=%0d rdata=%h, want 0 1 0 0 00",
                     o_level, o_rempty, o_woverflow, o_peak, o_rdata);
        else n_pass++;
        drive(1'b1, 8'h42, 1'b0);
        n_chk++;
        if ({o_rdata, o_level} !== {8'h42, 3'd1})
            $display("FAIL after_flush_write: rdata=%h level=%0d, want 42 1", o_rdata, o_level);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [19:0] obs;
        drive(1'b1, 8'hD1, 1'b0);
        i_wen   = 1'b1;
        i_wdata = 8'hD2;
        #2 rstn = 1'b0;
        #1;
        obs = {o_rempty, o_ralmost_empty, o_wfull, o_walmost_full, o_woverflow,
               o_runderflow, o_level, o_peak, o_rdata};
        n_chk++;
        if (obs !== RESET_VEC) $display("FAIL async_reset: got %h, want %h", obs, RESET_VEC);
        else n_pass++;
        i_wen = 1'b0;
        sb.delete();
        exp_peak = 0;
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({o_rempty, o_level} !== {1'b1, 3'd0})
            $display("FAIL reset_release: empty=%b level=%0d, want 1 0", o_rempty, o_level);
        else n_pass++;
        drive(1'b1, 8'hE7, 1'b0);
        n_chk++;
        if ({o_rdata, o_level} !== {8'hE7, 3'd1})
            $display("FAIL post_reset_write: rdata=%h level=%0d, want e7 1", o_rdata, o_level);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fwft();
        test_overflow();
        test_underflow_write();
        test_full_pop_write();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
